// File: rtl/piso_scan_pkg.sv
// Shared types and helpers for the PISO scan controller.
// State encoding, counter sizing and parameter checks.
package piso_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Counter must reach DATA_W-1 in SHIFT and LOAD_CYCLES-1 in LOAD.
  function automatic int cnt_width(input int data_w,
                                   input int load_cycles);
    int n;
    n = (load_cycles > data_w + 1) ? load_cycles : data_w + 1;
    return $clog2(n);
  endfunction

  function automatic bit params_ok(input int data_w,
                                   input int load_cycles);
    return (data_w >= 2) && (load_cycles >= 1);
  endfunction

endpackage

// File: rtl/piso_scan_controller_sipo.sv
// Serial-in capture register for the scan controller.
// Shifts the new bit in at the LSB; MSB is the first bit received.
module sipo_capture_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  // Capture one serial bit per enabled edge.
  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (en)
      q <= {q[DATA_W-2:0], din};
  end

endmodule

// File: rtl/piso_scan_controller.sv
// Sequencer for a 74HC165-style PISO chain.
// Loads, shifts out and deserialises one frame per request.
module piso_scan_controller
  import piso_scan_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LOAD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              qh,
  output logic              sh_ld_n,
  output logic              clk_inh,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy
);

  localparam int CW = cnt_width(DATA_W, LOAD_CYCLES);

  localparam logic [CW-1:0] LOAD_LAST =
    CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LAST =
    CW'(DATA_W - 1);

  if (!params_ok(DATA_W, LOAD_CYCLES)) begin : g_bad
    $error("piso_scan_controller: bad DATA_W/LOAD_CYCLES");
  end

  scan_state_t       state;
  scan_state_t       state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic              cap_en;
  logic              cap_clr;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] cap_next;

  assign cap_next = {cap_q[DATA_W-2:0], qh};

  sipo_capture_reg #(
    .DATA_W(DATA_W)
  ) u_cap (
    .clk (clk),
    .rst (rst),
    .clr (cap_clr),
    .en  (cap_en),
    .din (qh),
    .q   (cap_q)
  );

  // Next-state, counter and capture-enable decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_en  = 1'b0;
    cap_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          cnt_n   = '0;
          cap_clr = 1'b1;
        end
      end
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        cap_en = 1'b1;
        if (cnt == SHIFT_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        cnt_n = '0;
        if (continuous || start) begin
          state_n = LOAD;
          cap_clr = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_ld_n <= 1'b1;
      clk_inh <= 1'b1;
      valid   <= 1'b0;
      busy    <= 1'b0;
      data    <= '0;
    end else begin
      sh_ld_n <= (state_n != LOAD);
      clk_inh <= (state_n != SHIFT);
      valid   <= (state_n == DONE);
      busy    <= (state_n != IDLE);
      if (state == SHIFT && state_n == DONE)
        data <= cap_next;
    end
  end

endmodule

// File: tb/tb_piso_scan_controller.sv
// Scoreboard bench for piso_scan_controller.
// Behavioural 74HC165 models feed qh back into two DUT instances.
module tb_piso_scan_controller;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic        cont8 = 1'b0;
  logic        cont16 = 1'b0;
  logic [7:0]  par8 = '0;
  logic [15:0] par16 = '0;
  logic [7:0]  sr8 = '0;
  logic [15:0] sr16 = '0;

  logic        qh8, sh_ld_n8, clk_inh8, valid8, busy8;
  logic [7:0]  data8;
  logic        qh16, sh_ld_n16, clk_inh16, valid16, busy16;
  logic [15:0] data16;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   k;
  logic pv8 = 1'b0;
  logic pv16 = 1'b0;
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  piso_scan_controller u8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .continuous (cont8),
    .qh         (qh8),
    .sh_ld_n    (sh_ld_n8),
    .clk_inh    (clk_inh8),
    .data       (data8),
    .valid      (valid8),
    .busy       (busy8)
  );

  piso_scan_controller #(
    .DATA_W      (16),
    .LOAD_CYCLES (2)
  ) u16 (
    .clk        (clk),
    .rst        (rst),
    .start      (start16),
    .continuous (cont16),
    .qh         (qh16),
    .sh_ld_n    (sh_ld_n16),
    .clk_inh    (clk_inh16),
    .data       (data16),
    .valid      (valid16),
    .busy       (busy16)
  );

  // Register models: load when sh_ld_n low, shift toward H otherwise.
  always @(posedge clk) begin
    if (!sh_ld_n8)
      sr8 <= par8;
    else if (!clk_inh8)
      sr8 <= {sr8[6:0], 1'b0};
    if (!sh_ld_n16)
      sr16 <= par16;
    else if (!clk_inh16)
      sr16 <= {sr16[14:0], 1'b0};
  end

  assign qh8  = sr8[7];
  assign qh16 = sr16[15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, req, cyc);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each valid.
  always @(negedge clk) begin
    exp_t e;
    chk("ld_and_shift8", 32'(!sh_ld_n8 && !clk_inh8), 0);
    chk("ld_and_shift16", 32'(!sh_ld_n16 && !clk_inh16), 0);
    if (valid8) begin
      chk("double_valid8", 32'(pv8), 0);
      if (q8.size() == 0) begin
        chk("unexpected_valid8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("data8", 32'(data8), 32'(e.d));
        chk("latency8", cyc, e.c);
      end
    end
    if (valid16) begin
      chk("double_valid16", 32'(pv16), 0);
      if (q16.size() == 0) begin
        chk("unexpected_valid16", 1, 0);
      end else begin
        e = q16.pop_front();
        chk("data16", 32'(data16), 32'(e.d));
        chk("latency16", cyc, e.c);
      end
    end
    pv8  <= valid8;
    pv16 <= valid16;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sh_ld_n", 32'(sh_ld_n8), 1);
    chk("rst_clk_inh", 32'(clk_inh8), 1);
    chk("rst_valid", 32'(valid8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_data8", 32'(data8), 0);
    chk("rst_data16", 32'(data16), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy8), 0);

    // Single frame
    par8 = 8'b10110110;
    k = cyc;
    start8 = 1'b1;
    q8.push_back('{16'h00B6, k + 10});
    @(negedge clk);
    start8 = 1'b0;
    chk("load_sh_ld_n", 32'(sh_ld_n8), 0);
    chk("load_clk_inh", 32'(clk_inh8), 1);
    chk("load_busy", 32'(busy8), 1);
    @(negedge clk);
    chk("shift_sh_ld_n", 32'(sh_ld_n8), 1);
    chk("shift_clk_inh", 32'(clk_inh8), 0);
    wait_until(k + 11);
    chk("single_idle_busy", 32'(busy8), 0);
    chk("single_hold_data", 32'(data8), 32'h B6);

    // Continuous: three frames, par changed between frames
    par8 = 8'hB6;
    cont8 = 1'b1;
    k = cyc;
    start8 = 1'b1;
    q8.push_back('{16'h00B6, k + 10});
    q8.push_back('{16'h005A, k + 20});
    q8.push_back('{16'h00FF, k + 30});
    @(negedge clk);
    start8 = 1'b0;
    wait_until(k + 10);
    par8 = 8'h5A;
    chk("cont_busy_done", 32'(busy8), 1);
    wait_until(k + 11);
    chk("cont_busy_reload", 32'(busy8), 1);
    chk("cont_reload_ld", 32'(sh_ld_n8), 0);
    wait_until(k + 20);
    par8 = 8'hFF;
    chk("cont_busy_2", 32'(busy8), 1);
    wait_until(k + 25);
    cont8 = 1'b0;
    wait_until(k + 31);
    chk("cont_end_busy", 32'(busy8), 0);
    chk("cont_end_data", 32'(data8), 32'hFF);

    // start held through LOAD and SHIFT: one frame only
    par8 = 8'h3C;
    k = cyc;
    start8 = 1'b1;
    q8.push_back('{16'h003C, k + 10});
    wait_until(k + 7);
    start8 = 1'b0;
    wait_until(k + 25);
    chk("held_idle_busy", 32'(busy8), 0);
    chk("held_queue", q8.size(), 0);

    // Reset at the 4th SHIFT edge
    par8 = 8'hC3;
    k = cyc;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_until(k + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sh_ld_n", 32'(sh_ld_n8), 1);
    chk("abort_clk_inh", 32'(clk_inh8), 1);
    chk("abort_data", 32'(data8), 0);
    chk("abort_valid", 32'(valid8), 0);
    chk("abort_busy", 32'(busy8), 0);
    wait_until(k + 14);
    chk("abort_no_valid_data", 32'(data8), 0);
    par8 = 8'h81;
    k = cyc;
    start8 = 1'b1;
    q8.push_back('{16'h0081, k + 10});
    @(negedge clk);
    start8 = 1'b0;
    wait_until(k + 12);

    // Chained 16-bit, two load cycles
    par16 = 16'hA5C3;
    k = cyc;
    start16 = 1'b1;
    q16.push_back('{16'hA5C3, k + 19});
    @(negedge clk);
    start16 = 1'b0;
    chk("ch_load1", 32'(sh_ld_n16), 0);
    @(negedge clk);
    chk("ch_load2", 32'(sh_ld_n16), 0);
    @(negedge clk);
    chk("ch_shift", 32'(sh_ld_n16), 1);
    wait_until(k + 21);
    chk("ch_idle_busy", 32'(busy16), 0);

    wait_until(cyc + 100);
    chk("pending8", q8.size(), 0);
    chk("pending16", q16.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
